// File: rtl/m_mem_ctrl.sv
// m_mem_ctrl: memory-stage load/store controller driving a req/ack word bus, with alignment checks and a bus timeout
module m_mem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_M,
  input  logic [31:0] ALU_OUT_M,
  input  logic [31:0] FRead_Data_2_M,
  input  logic [4:0]  EXP_M,
  input  logic        FLUSH_M,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK,
  output logic        STALL_M,
  output logic [31:0] MEM_RDATA_M,
  output logic [4:0]  EXP_OUT_M
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] op;
  logic ld, st, half, word, uns, misal, valid, tmo;
  logic [3:0] be_nx;
  logic [31:0] wd_nx, ld_data;
  logic [15:0] cnt;
  logic err, drop, r_half, r_word, r_uns;
  logic [1:0] r_lane;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;
  logic unused_instr;
  assign unused_instr = ^INSTR_M[25:0];
  assign op = INSTR_M[31:26];
  always_comb begin
    ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st = op inside {6'h28, 6'h29, 6'h2b};
    half = op inside {6'h21, 6'h25, 6'h29};
    word = op inside {6'h23, 6'h2b};
    uns = op inside {6'h24, 6'h25};
    misal = (ld | st) && ((half && ALU_OUT_M[0]) || (word && ALU_OUT_M[1:0] != 2'b00));
    valid = (ld | st) && EXP_M == 5'd0 && !misal && !FLUSH_M;
    be_nx = word ? 4'hf : half ? (ALU_OUT_M[1] ? 4'hc : 4'h3) : 4'b0001 << ALU_OUT_M[1:0];
    wd_nx = word ? FRead_Data_2_M : half ? {2{FRead_Data_2_M[15:0]}} : {4{FRead_Data_2_M[7:0]}};
  end
  // load alignment uses the lane/size captured at launch, not the live pipeline inputs
  always_comb begin
    lane_byte = BUS_RDATA[{r_lane, 3'b000} +: 8];
    lane_half = r_lane[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    ld_data = r_word ? BUS_RDATA :
              r_half ? {{16{~r_uns & lane_half[15]}}, lane_half} :
                       {{24{~r_uns & lane_byte[7]}}, lane_byte};
  end
  assign tmo = cnt == 16'(TIMEOUT_CYC - 1) && !BUS_ACK;
  always_comb begin
    state_nx = state;
    STALL_M = 1'b0;
    EXP_OUT_M = 5'd0;
    case (state)
      IDLE: begin
        STALL_M = valid;
        EXP_OUT_M = EXP_M != 5'd0 ? EXP_M : misal ? (st ? 5'd5 : 5'd4) : 5'd0;
        state_nx = valid ? BUSY : IDLE;
      end
      BUSY: begin
        STALL_M = 1'b1;
        state_nx = (BUS_ACK || tmo) ? DONE : BUSY;
      end
      DONE: begin
        EXP_OUT_M = (err && !drop) ? 5'd7 : 5'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      BUS_REQ <= 1'b0;
      BUS_WE <= 1'b0;
      BUS_ADDR <= 32'd0;
      BUS_BE <= 4'd0;
      BUS_WDATA <= 32'd0;
      MEM_RDATA_M <= 32'd0;
      cnt <= 16'd0;
      err <= 1'b0;
      drop <= 1'b0;
      r_half <= 1'b0;
      r_word <= 1'b0;
      r_uns <= 1'b0;
      r_lane <= 2'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (valid) begin
          BUS_REQ <= 1'b1;
          BUS_WE <= st;
          BUS_ADDR <= {ALU_OUT_M[31:2], 2'b00};
          BUS_BE <= be_nx;
          BUS_WDATA <= wd_nx;
          r_half <= half;
          r_word <= word;
          r_uns <= uns;
          r_lane <= ALU_OUT_M[1:0];
          cnt <= 16'd0;
          err <= 1'b0;
          drop <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          if (FLUSH_M) drop <= 1'b1;
          if (BUS_ACK || tmo) BUS_REQ <= 1'b0;
          if (tmo) err <= 1'b1;
          if (BUS_ACK && !BUS_WE && !drop && !FLUSH_M) MEM_RDATA_M <= ld_data;
        end
        DONE: begin
          cnt <= 16'd0;
          err <= 1'b0;
          drop <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_m_mem_ctrl.sv
// tb_m_mem_ctrl: directed plus randomized checks of m_mem_ctrl against a byte-level access model
module tb_m_mem_ctrl;
  logic clk = 1'b0, reset;
  logic [31:0] INSTR_M, ALU_OUT_M, FRead_Data_2_M, BUS_ADDR, BUS_WDATA, BUS_RDATA, MEM_RDATA_M;
  logic [4:0] EXP_M, EXP_OUT_M;
  logic FLUSH_M, BUS_REQ, BUS_WE, BUS_ACK, STALL_M;
  logic [3:0] BUS_BE;
  int checks = 0, errors = 0;
  logic [31:0] exp_mem = 32'd0;
  logic [5:0] ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};

  m_mem_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .INSTR_M(INSTR_M), .ALU_OUT_M(ALU_OUT_M),
    .FRead_Data_2_M(FRead_Data_2_M), .EXP_M(EXP_M), .FLUSH_M(FLUSH_M),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .STALL_M(STALL_M), .MEM_RDATA_M(MEM_RDATA_M), .EXP_OUT_M(EXP_OUT_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void decode(input logic [5:0] op, output bit m, output bit l, output int n, output bit s);
    m = 1; l = 1; n = 1; s = 1;
    case (op)
      6'h20: ;
      6'h21: n = 2;
      6'h23: n = 4;
      6'h24: s = 0;
      6'h25: begin n = 2; s = 0; end
      6'h28: l = 0;
      6'h29: begin l = 0; n = 2; end
      6'h2b: begin l = 0; n = 4; end
      default: m = 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input int n, input bit s, input logic [31:0] addr, input logic [31:0] rd);
    int a = int'(addr & 32'd3);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'((rd >> (8 * (a + k))) & 32'hff) << (8 * k);
    if (s && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic logic [31:0] store_val(input int n, input logic [31:0] d);
    longint mask = (longint'(1) << (8 * n)) - 1;
    longint w = 0;
    for (int k = 0; k < 4 / n; k++) w |= (longint'(d) & mask) << (8 * n * k);
    return w[31:0];
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data, input logic [4:0] e);
    INSTR_M = {op, 26'($urandom)};
    ALU_OUT_M = addr;
    FRead_Data_2_M = data;
    EXP_M = e;
    FLUSH_M = 1'b0;
    BUS_ACK = 1'b0;
    #1;
  endtask

  task automatic idle_nop();
    INSTR_M = 32'd0; EXP_M = 5'd0; FLUSH_M = 1'b0; BUS_ACK = 1'b0;
  endtask

  // one access from IDLE through DONE and back to IDLE; entry/exit is 1 time unit after a rising edge
  task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int waits, input bit flush, input logic [4:0] e);
    bit m, l, s, mis, valid;
    int n, stalls;
    logic [4:0] xe;
    decode(op, m, l, n, s);
    mis = m && (int'(addr & 32'd3) % n) != 0;
    valid = m && e == 0 && !mis;
    xe = e != 0 ? e : mis ? (l ? 5'd4 : 5'd5) : 5'd0;
    drive(op, addr, data, e);
    chk("idle_stall", 32'(STALL_M), 32'(valid));
    chk("idle_exp", 32'(EXP_OUT_M), 32'(xe));
    @(posedge clk); #1;
    if (!valid) begin
      chk("no_req", 32'(BUS_REQ), 0);
      chk("no_stall", 32'(STALL_M), 32'(valid));
      idle_nop();
      return;
    end
    stalls = 1;
    chk("busy_req", 32'(BUS_REQ), 1);
    chk("busy_addr", BUS_ADDR, addr & ~32'd3);
    chk("busy_be", 32'(BUS_BE), (((32'd1 << n) - 1) << (addr & 32'd3)) & 32'hf);
    chk("busy_we", 32'(BUS_WE), 32'(!l));
    if (!l) chk("busy_wdata", BUS_WDATA, store_val(n, data));
    FLUSH_M = flush;
    for (int i = 0; i < waits; i++) begin
      BUS_RDATA = $urandom;
      #1 stalls += int'(STALL_M);
      chk("wait_req", 32'(BUS_REQ), 1);
      @(posedge clk); #1;
      FLUSH_M = 1'b0;
    end
    BUS_ACK = 1'b1;
    BUS_RDATA = rdata;
    #1 stalls += int'(STALL_M);
    @(posedge clk); #1;
    BUS_ACK = 1'b0;
    FLUSH_M = 1'b0;
    if (l && !flush) exp_mem = load_val(n, s, addr, rdata);
    chk("done_stall", 32'(STALL_M), 0);
    chk("done_req", 32'(BUS_REQ), 0);
    chk("done_exp", 32'(EXP_OUT_M), 0);
    chk("done_rdata", MEM_RDATA_M, exp_mem);
    chk("stall_cycles", 32'(stalls), 32'(2 + waits));
    BUS_ACK = 1'b1;
    BUS_RDATA = $urandom;
    @(posedge clk); #1;
    BUS_ACK = 1'b0;
    chk("no_launch_in_done", 32'(BUS_REQ), 0);
    chk("ack_ignored", MEM_RDATA_M, exp_mem);
    idle_nop();
  endtask

  initial begin
    int req_cycles;
    reset = 1'b0;
    BUS_RDATA = 32'd0;
    ALU_OUT_M = 32'd0;
    FRead_Data_2_M = 32'd0;
    idle_nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_req", 32'(BUS_REQ), 0);
    chk("rst_we", 32'(BUS_WE), 0);
    chk("rst_addr", BUS_ADDR, 0);
    chk("rst_be", 32'(BUS_BE), 0);
    chk("rst_wdata", BUS_WDATA, 0);
    chk("rst_rdata", MEM_RDATA_M, 0);
    chk("rst_stall", 32'(STALL_M), 0);
    chk("rst_exp", 32'(EXP_OUT_M), 0);
    @(posedge clk); #1;
    do_op(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    chk("lw_result", MEM_RDATA_M, 32'hDEADBEEF);
    do_op(6'h20, 32'h103, 32'h0, 32'h80112233, 0, 0, 0);
    chk("lb_result", MEM_RDATA_M, 32'hFFFFFF80);
    do_op(6'h24, 32'h103, 32'h0, 32'h80112233, 1, 0, 0);
    chk("lbu_result", MEM_RDATA_M, 32'h00000080);
    do_op(6'h21, 32'h102, 32'h0, 32'h80112233, 2, 0, 0);
    chk("lh_result", MEM_RDATA_M, 32'hFFFF8011);
    do_op(6'h28, 32'h201, 32'h000000A5, 32'h0, 0, 0, 0);
    do_op(6'h29, 32'h202, 32'h00001234, 32'h0, 1, 0, 0);
    do_op(6'h23, 32'h102, 32'h0, 32'h0, 0, 0, 0);
    do_op(6'h29, 32'h301, 32'h0, 32'h0, 0, 0, 0);
    do_op(6'h23, 32'h100, 32'h0, 32'h0, 0, 0, 5'd10);
    // flush in IDLE suppresses the launch
    drive(6'h23, 32'h100, 32'h0, 0);
    FLUSH_M = 1'b1;
    #1 chk("flush_idle_stall", 32'(STALL_M), 0);
    @(posedge clk); #1;
    chk("flush_idle_req", 32'(BUS_REQ), 0);
    idle_nop();
    // flush during BUSY: cycle completes, result discarded
    do_op(6'h23, 32'h180, 32'h0, 32'h12345678, 2, 1, 0);
    chk("flush_busy_hold", MEM_RDATA_M, 32'hFFFF8011);
    // timeout with no acknowledge
    drive(6'h23, 32'h400, 32'h0, 0);
    @(posedge clk); #1;
    req_cycles = 0;
    while (BUS_REQ && req_cycles < 40) begin
      req_cycles++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", 32'(req_cycles), 8);
    chk("tmo_stall", 32'(STALL_M), 0);
    chk("tmo_exp", 32'(EXP_OUT_M), 7);
    chk("tmo_rdata_hold", MEM_RDATA_M, exp_mem);
    idle_nop();
    @(posedge clk); #1;
    chk("tmo_after_exp", 32'(EXP_OUT_M), 0);
    // reset in BUSY drops the request without waiting for a clock
    drive(6'h23, 32'h40, 32'h0, 0);
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(BUS_REQ), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(BUS_REQ), 0);
    chk("async_rst_rdata", MEM_RDATA_M, 0);
    exp_mem = 32'd0;
    idle_nop();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_op(6'h23, 32'h44, 32'h0, 32'hCAFEF00D, 1, 0, 0);
    chk("post_rst_lw", MEM_RDATA_M, 32'hCAFEF00D);
    for (int t = 0; t < 60; t++) begin
      int sel = int'($urandom_range(0, 9));
      logic [5:0] op = sel < 8 ? ops[sel] : 6'($urandom);
      logic [4:0] e = $urandom_range(0, 7) == 0 ? 5'($urandom_range(1, 31)) : 5'd0;
      do_op(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)), $urandom_range(0, 5) == 0, e);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_mem_ctrl.md
# m_mem_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and performs the load or store on a word-wide data bus with a req/ack handshake. It decodes the memory opcode, generates byte enables and replicated store data, aligns and extends load data, detects misaligned addresses, and times out unresponsive bus cycles. While a bus cycle is in flight it stalls the pipeline, and it delivers the load result and exception code toward the MEM/WB register.

## Interface
- TIMEOUT_CYC, 255: BUSY cycles without BUS_ACK before the access is aborted with a bus error.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- INSTR_M  in  32  instruction in M; opcode in [31:26].
- ALU_OUT_M  in  32  effective byte address.
- FRead_Data_2_M  in  32  forwarded store data.
- EXP_M  in  5  upstream exception code; nonzero suppresses the access.
- FLUSH_M  in  1  cancels the instruction in M.
- BUS_REQ  out  1  bus request; registered.
- BUS_WE  out  1  1 = write.
- BUS_ADDR  out  32  word address, {ALU_OUT_M[31:2],2'b00}.
- BUS_BE  out  4  byte enables; bit k = byte lane k (little-endian).
- BUS_WDATA  out  32  store data, lane-replicated.
- BUS_RDATA  in  32  read data; valid when BUS_ACK=1.
- BUS_ACK  in  1  one-cycle completion pulse.
- STALL_M  out  1  holds IF..M pipeline registers.
- MEM_RDATA_M  out  32  aligned, extended load result; registered and held.
- EXP_OUT_M  out  5  exception code forwarded to W.

## Operation
- Decode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2b. Any other opcode is a non-memory instruction and passes through with no action.
- Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0. Produces EXP_OUT_M=4 (AdEL) for loads and 5 (AdES) for stores. No bus cycle, no stall.
- Valid access: memory opcode, EXP_M=0, aligned, FLUSH_M=0.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
- Store data: sb {4{d[7:0]}}, sh {2{d[15:0]}}, sw d.
- Load extract: select the addressed lane(s) of BUS_RDATA. lb/lh sign-extend; lbu/lhu zero-extend.
- EXP_OUT_M:
  - In IDLE: EXP_M if nonzero, else the misalignment code, else 0.
  - In DONE: the registered code, 7 (DBE) after a timeout, else 0.
- State machine:
  - IDLE: a valid access asserts STALL_M (combinational) and captures address, BE, WDATA, and WE. On the next edge it sets BUS_REQ=1 and goes to BUSY.
  - BUSY: BUS_REQ, BUS_ADDR, BUS_BE, BUS_WDATA, and BUS_WE are held stable and STALL_M=1. A 16-bit counter increments every cycle.
    - On the edge with BUS_ACK=1: load data is written into MEM_RDATA_M (loads only), BUS_REQ drops, and the state goes to DONE.
    - When the counter reaches TIMEOUT_CYC-1 with BUS_ACK=0: BUS_REQ drops, the error flag is set, and the state goes to DONE.
  - DONE: STALL_M=0 for exactly one cycle so the pipeline advances. No new launch is allowed in this state. Next state is IDLE and the counter clears.
- FLUSH_M:
  - In IDLE: suppresses the launch.
  - In BUSY: sets a drop flag. The bus cycle still completes, so a store commits. MEM_RDATA_M is not updated and EXP_OUT_M=0 in DONE.
- BUS_ACK while in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, BUS_REQ 0, BUS_WE 0, BUS_ADDR 0, BUS_BE 0, BUS_WDATA 0, MEM_RDATA_M 0, counter 0, error and drop flags 0. STALL_M and EXP_OUT_M then follow the IDLE combinational rules.
- Reset asserted mid-BUSY drops BUS_REQ asynchronously. The transaction is abandoned.
- Latency with ACK in the first BUSY cycle:
  - STALL_M is high for 2 cycles (IDLE cycle + BUSY cycle).
  - MEM_RDATA_M is valid from the DONE cycle onward.
- Each extra wait cycle adds one stall cycle.
- Timeout: BUS_REQ is high for exactly TIMEOUT_CYC cycles, then DONE.
- Back-to-back memory ops: the second launches in the IDLE cycle immediately after DONE. Minimum issue interval is 3 cycles.
- MEM_RDATA_M holds its value until the next completed load.

## Test plan
- lw at 0x100, ACK after 3 wait cycles, RDATA=0xDEADBEEF:
  - BUS_BE=1111, BUS_ADDR=0x100.
  - STALL_M high for 5 cycles.
  - MEM_RDATA_M=0xDEADBEEF in DONE.
- lb at 0x103 with RDATA=0x80112233 → BE=1000, MEM_RDATA_M=0xFFFFFF80. Same access as lbu → 0x00000080. lh at 0x102 → BE=1100, 0xFFFF8011.
- sb at 0x201 with data 0x000000A5 → BE=0010, WDATA=0xA5A5A5A5, BUS_WE=1. sh at 0x202 with data 0x1234 → BE=1100, WDATA=0x12341234.
- Misaligned and suppressed accesses:
  - lw at 0x102 → EXP_OUT_M=4, BUS_REQ stays 0, STALL_M=0.
  - sh at 0x301 → EXP_OUT_M=5.
  - EXP_M=10 on lw → EXP_OUT_M=10 and no bus cycle.
- TIMEOUT_CYC=8 with BUS_ACK held 0 → BUS_REQ high for 8 cycles, then DONE with EXP_OUT_M=7. FLUSH_M asserted during a BUSY load → MEM_RDATA_M keeps its prior value.
- reset driven low during BUSY → BUS_REQ=0 immediately. After release, a new lw completes normally.
